cdb_arbiter: RTL and testbench

//  Shares the single common data bus among N execution units. Each unit raises
//  req with tag/wdata (exu side of exu2cdb_itf) and holds them until granted (rdy).
//  One winner per cycle is chosen round-robin and broadcast on the registered CDB
//  (mst side of cdb_itf) one cycle later, feeding the RFU, reservation stations and ROB.

---
 rtl/ooo_pkg.sv | 24 ++
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter_rr.sv | 44 ++++
 rtl/cdb_arbiter.sv | 82 ++++++++
 tb/tb_cdb_arbiter.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order core: tag width, CDB port map,
// the registered broadcast record and a small pointer-width helper.
package ooo_pkg;

    localparam int TAG_W     = 4;
    localparam int CDB_N_REQ = 3;

    // Fixed CDB requester slots
    localparam int CDB_ALU = 0;
    localparam int CDB_MUL = 1;
    localparam int CDB_LSU = 2;

    typedef struct packed {
        logic             wr;
        logic [TAG_W-1:0] tag;
        logic [31:0]      wdata;
    } cdb_bcast_t;

    // Bits needed to index n requesters; a single requester still gets one bit
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundles between the execution units and the CDB arbiter (exu2cdb_itf),
// and between the arbiter and the CDB consumers (cdb_itf).
interface exu2cdb_itf #(
    parameter int N_REQ = ooo_pkg::CDB_N_REQ,
    parameter int TAG_W = ooo_pkg::TAG_W
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*TAG_W-1:0] req_tag;
    logic [N_REQ*32-1:0]    req_wdata;
    logic [N_REQ-1:0]       rdy;

    // Execution-unit side raises requests and sees grants
    modport master (output req, output req_tag, output req_wdata, input rdy);
    // Arbiter side consumes requests and returns grants
    modport slave  (input req, input req_tag, input req_wdata, output rdy);
endinterface

interface cdb_itf #(
    parameter int TAG_W = ooo_pkg::TAG_W
);
    logic             wr;
    logic [TAG_W-1:0] tag;
    logic [31:0]      wdata;

    // Arbiter drives the broadcast
    modport master (output wr, output tag, output wdata);
    // RFU, reservation stations and ROB listen
    modport slave  (input wr, input tag, input wdata);
endinterface

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: scans from ptr upward with wrap and
// returns the first requester as a one-hot grant plus its index.
module rr_arbiter
    import ooo_pkg::*;
#(
    parameter int N     = CDB_N_REQ,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] winner,
    output logic             any_req
);

    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Walk ptr, ptr+1, ... with an explicit wrap so non-power-of-2 N works
    always_comb begin
        gnt     = '0;
        winner  = '0;
        any_req = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            idx = sum[PTR_W-1:0];
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
        if (any_req) begin
            gnt[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one execution unit per cycle round-robin,
// returns a one-hot rdy, and broadcasts the winner's tag/data one cycle later.
// TAG_W must match ooo_pkg::TAG_W since the broadcast register uses cdb_bcast_t.
module cdb_arbiter
    import ooo_pkg::*;
#(
    parameter int N_REQ = CDB_N_REQ,
    parameter int TAG_W = ooo_pkg::TAG_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    exu2cdb_itf.slave   exu,
    cdb_itf.master      cdb
);

    localparam int               PTR_W = ptr_width(N_REQ);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic [N_REQ-1:0] gnt;
    logic             any_req;
    logic             transfer;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      sel_wdata;
    cdb_bcast_t       bcast;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req     (exu.req),
        .ptr     (ptr),
        .gnt     (gnt),
        .winner  (winner),
        .any_req (any_req)
    );

    // A grant is a transfer: flush and reset suppress it entirely
    assign transfer = any_req & ~flush & rst_n;
    assign exu.rdy  = transfer ? gnt : '0;

    // Select the granted unit's payload (gnt is one-hot, so order is irrelevant)
    always_comb begin
        sel_tag   = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_tag   = exu.req_tag[i*TAG_W +: TAG_W];
                sel_wdata = exu.req_wdata[i*32 +: 32];
            end
        end
    end

    // Priority pointer moves just past the winner on every transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (winner == LAST) ? '0 : winner + 1'b1;
        end
    end

    // Broadcast register: valid for one cycle per transfer, payload held otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcast <= '0;
        end else if (transfer) begin
            bcast.wr    <= 1'b1;
            bcast.tag   <= sel_tag;
            bcast.wdata <= sel_wdata;
        end else begin
            bcast.wr    <= 1'b0;
        end
    end

    assign cdb.wr    = bcast.wr;
    assign cdb.tag   = bcast.tag;
    assign cdb.wdata = bcast.wdata;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with three requesters and 4-bit tags.
// Inputs change 1 time unit after each rising edge; rdy is sampled 1 unit
// later, and the registered broadcast right after the edge.
module tb_cdb_arbiter;

    logic clk;
    logic rst_n;
    logic flush;
    int   errors;
    int   checks;

    exu2cdb_itf #(.N_REQ(3), .TAG_W(4)) exu_if ();
    cdb_itf     #(.TAG_W(4))            cdb_if ();

    cdb_arbiter #(.N_REQ(3), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .exu   (exu_if.slave),
        .cdb   (cdb_if.master)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setPayload(input int u, input logic [3:0] t, input logic [31:0] d);
        exu_if.req_tag[u*4 +: 4]    = t;
        exu_if.req_wdata[u*32 +: 32] = d;
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic f);
        exu_if.req = r;
        flush      = f;
        #1;
    endtask

    logic [2:0] exp_gnt [6];
    int         exp_win [6];

    initial begin
        errors = 0;
        checks = 0;
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_win = '{0, 1, 2, 0, 1, 2};

        // Reset held with every unit requesting
        rst_n      = 1'b0;
        flush      = 1'b0;
        exu_if.req = 3'b111;
        for (int u = 0; u < 3; u++) setPayload(u, 4'(u + 1), 32'h1111_1111 * (u + 1));
        tick();
        tick();
        checkOutput("rst_rdy",   32'(exu_if.rdy), 32'h0);
        checkOutput("rst_wr",    32'(cdb_if.wr),  32'h0);
        checkOutput("rst_tag",   32'(cdb_if.tag), 32'h0);
        checkOutput("rst_wdata", cdb_if.wdata,    32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("first_gnt", 32'(exu_if.rdy), 32'b001);
        tick();
        checkOutput("first_wr",  32'(cdb_if.wr),  32'h1);
        checkOutput("first_tag", 32'(cdb_if.tag), 32'h1);

        // Single requester, ptr=1
        setPayload(1, 4'h5, 32'hDEADBEEF);
        applyStimulus(3'b010, 1'b0);
        checkOutput("single_rdy", 32'(exu_if.rdy), 32'b010);
        tick();
        applyStimulus(3'b000, 1'b0);
        checkOutput("idle_rdy",     32'(exu_if.rdy), 32'h0);
        checkOutput("single_wr",    32'(cdb_if.wr),  32'h1);
        checkOutput("single_tag",   32'(cdb_if.tag), 32'h5);
        checkOutput("single_wdata", cdb_if.wdata,    32'hDEADBEEF);
        tick();
        checkOutput("single_wr_drop",  32'(cdb_if.wr),  32'h0);
        checkOutput("single_tag_hold", 32'(cdb_if.tag), 32'h5);

        // Wrap and skip: ptr=2, units 0 and 1 requesting
        setPayload(0, 4'h7, 32'h7777_0000);
        setPayload(1, 4'h8, 32'h8888_0000);
        applyStimulus(3'b011, 1'b0);
        checkOutput("wrap_rdy0", 32'(exu_if.rdy), 32'b001);
        tick();
        applyStimulus(3'b010, 1'b0);
        checkOutput("wrap_rdy1", 32'(exu_if.rdy), 32'b010);
        checkOutput("wrap_tag0", 32'(cdb_if.tag), 32'h7);
        tick();
        applyStimulus(3'b000, 1'b0);
        checkOutput("wrap_tag1",   32'(cdb_if.tag), 32'h8);
        checkOutput("wrap_wdata1", cdb_if.wdata,    32'h8888_0000);

        // Flush with ptr=2; the broadcast registered last edge still shows
        setPayload(2, 4'h9, 32'h9999_0000);
        setPayload(0, 4'hA, 32'hAAAA_0000);
        applyStimulus(3'b101, 1'b1);
        checkOutput("flush_rdy",         32'(exu_if.rdy), 32'h0);
        checkOutput("flush_inflight_wr", 32'(cdb_if.wr),  32'h1);
        tick();
        applyStimulus(3'b101, 1'b0);
        checkOutput("flush_wr",       32'(cdb_if.wr),  32'h0);
        checkOutput("post_flush_rdy", 32'(exu_if.rdy), 32'b100);
        tick();
        applyStimulus(3'b001, 1'b0);
        checkOutput("post_flush_tag",  32'(cdb_if.tag), 32'h9);
        checkOutput("post_flush_rdy0", 32'(exu_if.rdy), 32'b001);
        tick();
        applyStimulus(3'b000, 1'b0);
        checkOutput("post_flush_tag0", 32'(cdb_if.tag), 32'hA);

        // Round-robin from a fresh reset, payload refreshed every cycle
        rst_n = 1'b0;
        applyStimulus(3'b111, 1'b0);
        checkOutput("rr_rst_rdy", 32'(exu_if.rdy), 32'h0);
        tick();
        rst_n = 1'b1;
        checkOutput("rr_rst_wr", 32'(cdb_if.wr), 32'h0);
        for (int k = 0; k < 6; k++) begin
            for (int u = 0; u < 3; u++) setPayload(u, 4'(k + 1), 32'h100 * u + k);
            applyStimulus(3'b111, 1'b0);
            checkOutput($sformatf("rr_gnt%0d", k), 32'(exu_if.rdy), 32'(exp_gnt[k]));
            tick();
            checkOutput($sformatf("rr_wr%0d", k),    32'(cdb_if.wr),  32'h1);
            checkOutput($sformatf("rr_tag%0d", k),   32'(cdb_if.tag), 32'(k + 1));
            checkOutput($sformatf("rr_wdata%0d", k), cdb_if.wdata,    32'h100 * exp_win[k] + k);
        end

        // Reset mid-stream: ptr is 1 after the next grant, reset returns it to 0
        for (int u = 0; u < 3; u++) setPayload(u, 4'hC, 32'hC0C0_0000);
        applyStimulus(3'b111, 1'b0);
        checkOutput("mid_gnt", 32'(exu_if.rdy), 32'b001);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_rdy",   32'(exu_if.rdy), 32'h0);
        checkOutput("mid_inflight",  32'(cdb_if.wr),  32'h1);
        tick();
        checkOutput("mid_rst_wr",  32'(cdb_if.wr),  32'h0);
        checkOutput("mid_rst_tag", 32'(cdb_if.tag), 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_restart", 32'(exu_if.rdy), 32'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
